// File: rtl/temp_avg_display.sv
// temp_avg_display: snapshots NR_SENSORS readings, averages the enabled ones
// with a serial restoring divider, rounds half-up, and produces a thermometer
// display code plus a debounced out-of-range alert.
module temp_avg_display #(
  parameter  int NR_SENSORS = 8,
  parameter  int TEMP_W     = 8,
  parameter  int LOW_LIMIT  = 19,
  parameter  int HIGH_LIMIT = 26,
  parameter  int ALERT_CNT  = 2,
  localparam int CODE_W     = HIGH_LIMIT - LOW_LIMIT + 1,
  localparam int CNT_W      = $clog2(NR_SENSORS + 1),
  localparam int SUM_W      = TEMP_W + $clog2(NR_SENSORS)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [NR_SENSORS*TEMP_W-1:0] sensors_i,
  input  logic [NR_SENSORS-1:0]        sensor_en_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [TEMP_W-1:0]            avg_o,
  output logic [CODE_W-1:0]            coded_out_o,
  output logic                         alert_o,
  output logic                         no_sensor_o
);

  // One step counter serves both the channel walk and the quotient bits.
  localparam int STEP_W = $clog2(NR_SENSORS + SUM_W);
  localparam int ST_W   = $clog2(ALERT_CNT + 1);

  localparam logic [STEP_W-1:0] ACC_LAST   = STEP_W'(NR_SENSORS - 1);
  localparam logic [STEP_W-1:0] DIV_LAST   = STEP_W'(SUM_W - 1);
  localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [TEMP_W-1:0] TEMP_ONE   = TEMP_W'(1);
  localparam logic [TEMP_W-1:0] LOW_T      = TEMP_W'(LOW_LIMIT);
  localparam logic [TEMP_W-1:0] HIGH_T     = TEMP_W'(HIGH_LIMIT);
  localparam logic [CODE_W-1:0] CODE_ONE   = CODE_W'(1);
  localparam logic [ST_W-1:0]   STREAK_ONE = ST_W'(1);
  localparam logic [ST_W-1:0]   STREAK_MAX = ST_W'(ALERT_CNT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DIVIDE,
    S_RESULT
  } state_t;

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;

  logic [NR_SENSORS*TEMP_W-1:0] sens_p0;
  logic [NR_SENSORS-1:0]        en_p0;
  logic [TEMP_W-1:0]            rd_p0;

  logic [SUM_W-1:0]    acc_p1;
  logic [CNT_W-1:0]    cnt_p1;

  logic [CNT_W:0]      rem_p2;
  logic [CNT_W+1:0]    rem_sh_p2;
  logic [CNT_W+1:0]    rem_sub_p2;
  logic                rem_ge_p2;

  logic                vld_p2;
  logic [TEMP_W-1:0]   avg_p2;
  logic [CODE_W-1:0]   code_p2;
  logic                oor_p2;
  logic [ST_W-1:0]     streak_q;
  logic [ST_W-1:0]     streak_nxt;

  // Half-up rounding of the quotient: bump when the remainder is at least
  // half the divisor. Only meaningful for a non-zero divisor.
  function automatic logic [TEMP_W-1:0] round_half_up(
    input logic [SUM_W-1:0] q,
    input logic [CNT_W:0]   r,
    input logic [CNT_W-1:0] d
  );
    logic [CNT_W+1:0] r2;
    r2 = {r, 1'b0};
    if (r2 >= {2'b00, d})
      return q[TEMP_W-1:0] + TEMP_ONE;
    return q[TEMP_W-1:0];
  endfunction

  // Streak counter increment that sticks at ALERT_CNT.
  function automatic logic [ST_W-1:0] sat_inc(input logic [ST_W-1:0] s);
    if (s >= STREAK_MAX)
      return STREAK_MAX;
    return s + STREAK_ONE;
  endfunction

  // Thermometer code: below range shows a single lit segment, above range
  // lights everything, in range lights (avg-LOW_LIMIT+1) low segments.
  function automatic logic [CODE_W-1:0] thermo_code(input logic [TEMP_W-1:0] a);
    logic [CODE_W-1:0] c;
    c = '0;
    if (a < LOW_T) begin
      c = CODE_ONE;
    end else begin
      for (int i = 0; i < CODE_W; i++)
        c[i] = (int'(a) >= LOW_LIMIT + i);
    end
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_ACCUM;
          step_d  = '0;
        end
      end
      S_ACCUM: begin
        if (step_q == ACC_LAST) begin
          state_d = S_DIVIDE;
          step_d  = '0;
        end else begin
          step_d  = step_q + STEP_ONE;
        end
      end
      S_DIVIDE: begin
        if (step_q == DIV_LAST) begin
          state_d = S_RESULT;
          step_d  = '0;
        end else begin
          step_d  = step_q + STEP_ONE;
        end
      end
      S_RESULT: begin
        state_d = S_IDLE;
        step_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        step_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);

  // ---- p0: input snapshot, consumed one channel per cycle from the bottom ----
  assign rd_p0 = en_p0[0] ? sens_p0[TEMP_W-1:0] : '0;

  // ---- p1: accumulation of enabled readings and enabled count ----
  // ---- p2: restoring division; quotient bits shift into acc_p1 ----
  assign rem_sh_p2  = {rem_p2, acc_p1[SUM_W-1]};
  assign rem_ge_p2  = (rem_sh_p2 >= {2'b00, cnt_p1});
  assign rem_sub_p2 = rem_sh_p2 - {2'b00, cnt_p1};

  always_ff @(posedge clk_i) begin
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          sens_p0 <= sensors_i;
          en_p0   <= sensor_en_i;
          acc_p1  <= '0;
          cnt_p1  <= '0;
          rem_p2  <= '0;
        end
      end
      S_ACCUM: begin
        sens_p0 <= sens_p0 >> TEMP_W;
        en_p0   <= en_p0 >> 1;
        acc_p1  <= acc_p1 + {{(SUM_W-TEMP_W){1'b0}}, rd_p0};
        if (en_p0[0])
          cnt_p1 <= cnt_p1 + CNT_ONE;
      end
      S_DIVIDE: begin
        rem_p2 <= rem_ge_p2 ? rem_sub_p2[CNT_W:0] : rem_sh_p2[CNT_W:0];
        acc_p1 <= {acc_p1[SUM_W-2:0], rem_ge_p2};
      end
      default: begin
      end
    endcase
  end

  // ---- result: rounding, display coding, alert debounce ----
  assign vld_p2     = (state_q == S_RESULT);
  assign avg_p2     = round_half_up(acc_p1, rem_p2, cnt_p1);
  assign code_p2    = thermo_code(avg_p2);
  assign oor_p2     = (avg_p2 < LOW_T) || (avg_p2 > HIGH_T);
  assign streak_nxt = oor_p2 ? sat_inc(streak_q) : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_o      <= 1'b0;
      avg_o       <= '0;
      coded_out_o <= '0;
      alert_o     <= 1'b0;
      no_sensor_o <= 1'b0;
      streak_q    <= '0;
    end else begin
      done_o <= vld_p2;
      if (vld_p2) begin
        if (cnt_p1 == '0) begin
          // No channel contributed: keep the last average and the streak.
          no_sensor_o <= 1'b1;
          alert_o     <= 1'b1;
          coded_out_o <= '0;
        end else begin
          no_sensor_o <= 1'b0;
          avg_o       <= avg_p2;
          coded_out_o <= code_p2;
          streak_q    <= streak_nxt;
          alert_o     <= (streak_nxt >= STREAK_MAX);
        end
      end
    end
  end

endmodule

// File: tb/tb_temp_avg_display.sv
// Directed testbench for temp_avg_display with default parameters.
module tb_temp_avg_display;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [63:0] sensors_i;
  logic [7:0]  sensor_en_i;
  logic        busy_o;
  logic        done_o;
  logic [7:0]  avg_o;
  logic [7:0]  coded_out_o;
  logic        alert_o;
  logic        no_sensor_o;

  int n_vec  = 0;
  int n_miss = 0;
  int lat;
  int bcnt;
  int dcnt;

  temp_avg_display dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .sensors_i   (sensors_i),
    .sensor_en_i (sensor_en_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .avg_o       (avg_o),
    .coded_out_o (coded_out_o),
    .alert_o     (alert_o),
    .no_sensor_o (no_sensor_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge: launches one operation and returns at the negedge
  // where done_o is seen. At cycle chg_at the inputs switch to s_alt and
  // start_i is pulsed again (both must be ignored).
  task automatic do_op(input logic [63:0] s, input logic [7:0] m, input int chg_at,
                       input logic [63:0] s_alt, output int l, output int b);
    sensors_i   = s;
    sensor_en_i = m;
    start_i     = 1'b1;
    l = 0;
    b = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (c == chg_at) begin
        sensors_i   = s_alt;
        sensor_en_i = 8'hFF;
        start_i     = 1'b1;
      end
      if (busy_o) b++;
      if (done_o) begin
        l = c;
        break;
      end
    end
    start_i = 1'b0;
    chk("done_within_bound", (l != 0), 1);
  endtask

  task automatic idle_count(input int n, output int d);
    d = 0;
    repeat (n) begin
      @(negedge clk);
      if (done_o) d++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_i       = 1'b1;
    start_i     = 1'b0;
    sensors_i   = '0;
    sensor_en_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy",  busy_o, 0);
    chk("rst_done",  done_o, 0);
    chk("rst_avg",   avg_o, 0);
    chk("rst_code",  coded_out_o, 0);
    chk("rst_alert", alert_o, 0);
    chk("rst_nosens", no_sensor_o, 0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk);

    // All channels at 22
    do_op({8{8'd22}}, 8'hFF, 0, '0, lat, bcnt);
    chk("b_latency", lat, 21);
    chk("b_busy_cycles", bcnt, 20);
    chk("b_busy_at_done", busy_o, 0);
    chk("b_avg", avg_o, 22);
    chk("b_code", coded_out_o, 8'h0F);
    chk("b_alert", alert_o, 0);
    chk("b_nosens", no_sensor_o, 0);
    @(negedge clk);
    chk("b_done_one_cycle", done_o, 0);
    chk("b_avg_hold", avg_o, 22);
    @(negedge clk);

    // Rounding up: 20,21,21 -> 62/3 = 20 r2 -> 21
    do_op({8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd21, 8'd21, 8'd20}, 8'h07, 0, '0, lat, bcnt);
    chk("rnd_up_avg", avg_o, 21);
    chk("rnd_up_code", coded_out_o, 8'h07);
    repeat (2) @(negedge clk);

    // Rounding down: 20,20,21 -> 61/3 = 20 r1 -> 20
    do_op({8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd21, 8'd20, 8'd20}, 8'h07, 0, '0, lat, bcnt);
    chk("rnd_dn_avg", avg_o, 20);
    chk("rnd_dn_code", coded_out_o, 8'h03);
    repeat (2) @(negedge clk);

    // Debounce
    do_op({8{8'd30}}, 8'hFF, 0, '0, lat, bcnt);
    chk("db1_code", coded_out_o, 8'hFF);
    chk("db1_alert", alert_o, 0);
    repeat (2) @(negedge clk);
    do_op({8{8'd30}}, 8'hFF, 0, '0, lat, bcnt);
    chk("db2_alert", alert_o, 1);
    repeat (2) @(negedge clk);
    do_op({8{8'd15}}, 8'hFF, 0, '0, lat, bcnt);
    chk("db3_avg", avg_o, 15);
    chk("db3_code", coded_out_o, 8'h01);
    chk("db3_alert", alert_o, 1);
    repeat (2) @(negedge clk);
    do_op({8{8'd23}}, 8'hFF, 0, '0, lat, bcnt);
    chk("db4_code", coded_out_o, 8'h1F);
    chk("db4_alert", alert_o, 0);
    repeat (2) @(negedge clk);

    // No enabled sensors
    do_op({8{8'd22}}, 8'hFF, 0, '0, lat, bcnt);
    chk("ns_pre_avg", avg_o, 22);
    repeat (2) @(negedge clk);
    do_op({8{8'd40}}, 8'h00, 0, '0, lat, bcnt);
    chk("ns_latency", lat, 21);
    chk("ns_flag", no_sensor_o, 1);
    chk("ns_alert", alert_o, 1);
    chk("ns_code", coded_out_o, 0);
    chk("ns_avg_held", avg_o, 22);
    repeat (2) @(negedge clk);
    do_op({8{8'd22}}, 8'hFF, 0, '0, lat, bcnt);
    chk("ns_recover_flag", no_sensor_o, 0);
    chk("ns_recover_alert", alert_o, 0);
    repeat (2) @(negedge clk);

    // Snapshot: inputs change and start pulses during ACCUM
    do_op({8{8'd25}}, 8'hFF, 3, {8{8'd40}}, lat, bcnt);
    chk("snap_latency", lat, 21);
    chk("snap_avg", avg_o, 25);
    chk("snap_code", coded_out_o, 8'h7F);
    idle_count(30, dcnt);
    chk("snap_single_done", dcnt, 0);
    chk("snap_idle_busy", busy_o, 0);

    // Back-to-back: second start issued in the done cycle
    do_op({8{8'd21}}, 8'hFF, 0, '0, lat, bcnt);
    chk("b2b_first_avg", avg_o, 21);
    do_op({8{8'd24}}, 8'hFF, 0, '0, lat, bcnt);
    chk("b2b_latency", lat, 21);
    chk("b2b_avg", avg_o, 24);
    chk("b2b_code", coded_out_o, 8'h3F);
    repeat (2) @(negedge clk);

    // Mid-operation reset
    do_op({8{8'd40}}, 8'h00, 0, '0, lat, bcnt);
    chk("pre_rst_alert", alert_o, 1);
    repeat (2) @(negedge clk);
    sensors_i   = {8{8'd22}};
    sensor_en_i = 8'hFF;
    start_i     = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy_before_rst", busy_o, 1);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_busy",  busy_o, 0);
    chk("mid_rst_done",  done_o, 0);
    chk("mid_rst_avg",   avg_o, 0);
    chk("mid_rst_code",  coded_out_o, 0);
    chk("mid_rst_alert", alert_o, 0);
    chk("mid_rst_nosens", no_sensor_o, 0);
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    idle_count(30, dcnt);
    chk("abort_no_done", dcnt, 0);
    do_op({8{8'd27}}, 8'hFF, 0, '0, lat, bcnt);
    chk("post_rst_latency", lat, 21);
    chk("post_rst_avg", avg_o, 27);
    chk("post_rst_code", coded_out_o, 8'hFF);
    chk("post_rst_alert", alert_o, 0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/temp_avg_display.md
# temp_avg_display

Sequential, parametrised temperature averaging and display encoder for the temperature-monitoring datapath. On a start pulse it snapshots NR_SENSORS sensor readings and their enable mask, accumulates the enabled readings, divides by the enabled count with a serial restoring divider, and rounds half-up. It then drives a thermometer-coded display word and a debounced out-of-range alert. It sits between the sensor sampling stage and the display/alarm logic.

## Interface
- NR_SENSORS, 8, number of sensor channels (≥2)
- TEMP_W, 8, width of one unsigned reading and of the average
- LOW_LIMIT, 19, lowest in-range average
- HIGH_LIMIT, 26, highest in-range average
- ALERT_CNT, 2, consecutive out-of-range results needed to assert alert (≥1)
- Derived: CODE_W = HIGH_LIMIT-LOW_LIMIT+1; CNT_W = clog2(NR_SENSORS+1); SUM_W = TEMP_W+clog2(NR_SENSORS)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  start request, sampled only in IDLE
- sensors_i  in  NR_SENSORS*TEMP_W  packed readings, channel k at bits [k*TEMP_W +: TEMP_W]
- sensor_en_i  in  NR_SENSORS  channel enable mask
- busy_o  out  1  operation in progress
- done_o  out  1  one-cycle pulse, result outputs just updated
- avg_o  out  TEMP_W  rounded average
- coded_out_o  out  CODE_W  thermometer display code
- alert_o  out  1  debounced alert
- no_sensor_o  out  1  last result had zero enabled channels

## Operation
- Reset values: all outputs 0. Internal state IDLE, out-of-range streak counter 0.
- IDLE: on start_i=1, snapshot sensors_i and sensor_en_i, then go to ACCUM. Input changes after the snapshot have no effect. start_i is ignored in every other state.
- ACCUM: one channel per cycle, channel 0 first, NR_SENSORS cycles. Enabled readings are added into a SUM_W-bit sum; the enabled count goes into a CNT_W-bit counter. No overflow is possible.
- DIVIDE: restoring division sum/count, one quotient bit per cycle, SUM_W cycles. It always runs, even with count=0, so latency is fixed.
- RESULT (1 cycle):
  - Rounding: if 2*R ≥ count, avg = Q+1; otherwise avg = Q. The result always fits in TEMP_W.
  - Coding: avg < LOW_LIMIT gives code 1. avg > HIGH_LIMIT gives all ones. Otherwise the low (avg-LOW_LIMIT+1) bits are 1 and the rest 0.
  - Alert streak: an out-of-range avg increments the streak, saturating at ALERT_CNT. An in-range avg clears it. alert_o = (streak ≥ ALERT_CNT), using the updated streak value.
  - count=0: no_sensor_o=1, alert_o=1, coded_out_o=0, avg_o held, streak held. Otherwise no_sensor_o=0.
  - After RESULT, return to IDLE.
- Reset asserted mid-operation aborts the operation: all outputs and state return to reset values and no done_o is generated.

## Timing
- E0 is the edge that samples start_i=1 in IDLE. busy_o goes to 1 after E0.
- ACCUM occupies edges E1..E(NR_SENSORS).
- DIVIDE occupies the next SUM_W edges.
- Edge E(NR_SENSORS+SUM_W+1) updates avg_o, coded_out_o, alert_o and no_sensor_o, sets done_o=1 and busy_o=0.
- The next edge clears done_o. A start_i sampled at that edge is accepted, giving back-to-back operations.
- With default parameters, done_o is high in the cycle after E20.
- Result outputs hold their values between done_o pulses.

## Test plan
- Reset, then all 8 channels enabled at 22 → done_o in the cycle after E20, avg_o=22, coded_out_o=0x0F, alert_o=0, busy_o high for exactly 20 cycles.
- Rounding, mask 0x07:
  - Readings 20,21,21 (sum 62, R=2) → avg_o=21, coded_out_o=0x07.
  - Readings 20,20,21 (sum 61, R=1) → avg_o=20, coded_out_o=0x03.
- Debounce (ALERT_CNT=2):
  - Average 30 → coded_out_o=0xFF, alert_o=0.
  - Average 30 again → alert_o=1.
  - Average 15 → coded_out_o=0x01, alert_o=1 (streak saturated).
  - Average 23 → coded_out_o=0x1F, alert_o=0.
- sensor_en_i=0 after a result of 22 → no_sensor_o=1, alert_o=1, coded_out_o=0, avg_o stays 22, latency unchanged. The next valid 22 result → no_sensor_o=0, alert_o=0.
- Snapshot and start rules:
  - Change sensors_i and pulse start_i during ACCUM → result reflects the snapshot only, and only one done_o is produced.
  - start_i high in the done_o cycle → second operation starts immediately.
- Assert rst_i during the 4th ACCUM cycle → all outputs 0 immediately, no done_o. A fresh start after release gives the correct result with full latency.
